cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle sequencer that drives the 8-bit CPU's register file, ALU and RAM. It fetches one- or two-byte instructions from RAM and decodes them. It issues register-file read addresses, write address, write enable and write-data source select, and updates the PC. It sits between the RAM and the datapath. The five-entry register file uses r0–r2 general, r3 = ACC, r4 = COUNT.

## Interface
- No parameters; data, address and PC widths are fixed at 8 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_dout  in  8  RAM read data, valid the cycle after mem_re
- alu_zero  in  1  ALU result c == 0, combinational
- mem_addr  out  8  RAM address
- mem_re  out  1  RAM read strobe
- mem_we  out  1  RAM write strobe; RAM din is wired to rf rda
- rf_we  out  1  register-file write enable
- rf_wa / rf_ra / rf_rb  out  3 each  register-file write / read-A / read-B address
- wd_sel  out  2  write-data source: 0 = ALU c, 1 = ACC, 2 = mem_dout
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 DEC (c = a−1)
- pc  out  8  program counter
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- Byte0 = op[7:3], r[2:0]. Byte1 = immediate or address.
- Opcodes:
  - 00 NOP
  - 01 LDI r,imm
  - 02 LD r,[a]
  - 03 ST r,[a]
  - 04 ADD, 05 SUB, 06 AND, 07 OR, 08 XOR r, each computing ACC <= ACC op r with ra=3, rb=r, wa=3, wd_sel=0
  - 09 MOV r (r <= ACC, wd_sel=1)
  - 0A JMP a
  - 0B DJNZ a (COUNT <= COUNT−1; if result ≠ 0 then pc <= a)
  - 1F HLT
- Any other opcode is illegal.
- If the op uses r (LDI, LD, ST, ALU ops, MOV) and r > 4, the instruction is illegal. NOP, JMP, DJNZ and HLT ignore r.
- States and actions:
  - FETCH: mem_addr=pc, mem_re=1.
  - DECODE: IR <= mem_dout, pc <= pc+1.
  - FETCH_OP: mem_addr=pc, mem_re=1.
  - LATCH_OP: OPR <= mem_dout, pc <= pc+1.
  - EXEC: executes the decoded instruction.
  - MEM_WAIT: completes LD.
  - HALT: idle.
- Transitions out of DECODE:
  - Illegal: pulse illegal, go to FETCH.
  - NOP: go to FETCH.
  - HLT: go to HALT.
  - ALU op / MOV: go to EXEC.
  - Two-byte op: go to FETCH_OP.
- LATCH_OP actions by opcode:
  - LDI: rf_we=1, wa=r, wd_sel=2, then FETCH.
  - JMP: pc <= mem_dout (overrides the increment), then FETCH.
  - LD / ST / DJNZ: go to EXEC.
- EXEC actions by opcode:
  - ALU op / MOV: rf_we=1.
  - ST: mem_addr=OPR, mem_we=1, ra=r.
  - LD: mem_addr=OPR, mem_re=1, then MEM_WAIT.
  - DJNZ: ra=4, alu_op=5, wa=4, rf_we=1; if !alu_zero then pc <= OPR.
  - All cases except LD return to FETCH.
- MEM_WAIT (LD): rf_we=1, wa=r, wd_sel=2, then FETCH.
- HALT persists until reset. halted=1.
- PC arithmetic is modulo 256: 0xFF+1 = 0x00. This applies to both the byte0 and byte1 increments.

## Timing
- Instruction latency in cycles:
  - NOP / HLT / illegal: 2
  - ALU op / MOV: 3
  - LDI / JMP: 4
  - ST / DJNZ: 5
  - LD: 6
- Outputs are Moore decodes of state, IR and OPR. The one exception is DJNZ's pc update, which samples alu_zero in EXEC.
- The register-file write commits on the clk edge that ends the state asserting rf_we. A following instruction's read sees the new value.
- Reset state and outputs:
  - During reset: state=FETCH, pc=0, IR=OPR=0.
  - While reset is high, all strobes (mem_re, mem_we, rf_we, illegal) are forced to 0, and halted=0.
  - Address and select outputs are 0 during reset.
- Reset mid-instruction aborts the instruction: no write and no PC change.
- In the first cycle after reset deasserts, the unit is in FETCH with mem_addr=0x00 and mem_re=1.
- mem_re and mem_we are never high together. rf_we and mem_we are never high together.

## Structure
- Package cpu_pkg holds the shared constants:
  - opcode constants
  - alu_op codes
  - wd_sel codes
  - REG_ACC=3, REG_COUNT=4
  - the state enum
- The ALU and register file use cpu_pkg as well.
- Sub-module cpu_decoder is combinational. It maps IR to: class (ALU, MOV, LDI, LD, ST, JMP, DJNZ, NOP, HLT), alu_op, two_byte and illegal.

## Test plan
- Reset, then program 0x08,0x2A (LDI r0,0x2A): rf_we high in cycle 4 with wa=0, wd_sel=2, mem_dout=0x2A; pc=0x02 afterwards.
- LDI r3,5 then ADD r0 (0x20) with r0=0x2A: in EXEC, ra=3, rb=0, alu_op=0, wa=3, rf_we=1.
- LDI r4,3; DJNZ back to the DJNZ address: the branch is taken twice, falls through on the third pass (alu_zero=1), and pc ends at DJNZ address+2.
- ST r1,[0x80] then LD r2,[0x80]:
  - ST: mem_we pulses with mem_addr=0x80, ra=1.
  - LD: mem_re at 0x80, then rf_we with wa=2, wd_sel=2 one cycle later.
- Opcodes 0x60 and 0x25 (ADD r5): each produces a one-cycle illegal pulse, no rf_we, and pc advances by 1.
- Conditions:
  - HLT (0xF8): halted=1 and all strobes stay 0 indefinitely.
  - Reset asserted during LD's MEM_WAIT: no rf_we, pc=0, restart from FETCH.
  - JMP 0xFF followed by NOP at 0xFF: pc wraps to 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit CPU: opcodes, ALU codes,
// write-data selects, special register indices and sequencer states.
package cpu_pkg;

  // Opcode field values (byte0[7:3])
  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_LD   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_SUB  = 5'h05;
  localparam logic [4:0] OP_AND  = 5'h06;
  localparam logic [4:0] OP_OR   = 5'h07;
  localparam logic [4:0] OP_XOR  = 5'h08;
  localparam logic [4:0] OP_MOV  = 5'h09;
  localparam logic [4:0] OP_JMP  = 5'h0A;
  localparam logic [4:0] OP_DJNZ = 5'h0B;
  localparam logic [4:0] OP_HLT  = 5'h1F;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_DEC = 3'd5;

  // Register-file write-data source selects
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_ACC = 2'd1;
  localparam logic [1:0] WD_MEM = 2'd2;

  // Register-file layout: r0..r2 general, r3 accumulator, r4 loop counter
  localparam logic [2:0] REG_ACC   = 3'd3;
  localparam logic [2:0] REG_COUNT = 3'd4;
  localparam logic [2:0] REG_LAST  = 3'd4;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StFetchOp,
    StLatchOp,
    StExec,
    StMemWait,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsNop,
    ClsHlt,
    ClsAlu,
    ClsMov,
    ClsLdi,
    ClsLd,
    ClsSt,
    ClsJmp,
    ClsDjnz
  } op_class_e;

  // Opcodes LDI..MOV carry a register operand that must name r0..r4
  function automatic logic op_uses_reg(input logic [4:0] op);
    return (op >= OP_LDI) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: classifies byte0 of an instruction and
// flags undecodable opcodes or out-of-range register operands.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output op_class_e  op_class,
  output logic [2:0] alu_op,
  output logic       two_byte,
  output logic       illegal
);

  logic [4:0] op;
  logic [2:0] reg_sel;

  assign op      = ir[7:3];
  assign reg_sel = ir[2:0];

  // Map opcode to class, ALU function and length; illegal forms decode as NOP
  always_comb begin
    op_class = ClsNop;
    alu_op   = ALU_ADD;
    two_byte = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_NOP:  op_class = ClsNop;
      OP_LDI:  begin op_class = ClsLdi;  two_byte = 1'b1; end
      OP_LD:   begin op_class = ClsLd;   two_byte = 1'b1; end
      OP_ST:   begin op_class = ClsSt;   two_byte = 1'b1; end
      OP_ADD:  begin op_class = ClsAlu;  alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = ClsAlu;  alu_op = ALU_SUB; end
      OP_AND:  begin op_class = ClsAlu;  alu_op = ALU_AND; end
      OP_OR:   begin op_class = ClsAlu;  alu_op = ALU_OR;  end
      OP_XOR:  begin op_class = ClsAlu;  alu_op = ALU_XOR; end
      OP_MOV:  op_class = ClsMov;
      OP_JMP:  begin op_class = ClsJmp;  two_byte = 1'b1; end
      OP_DJNZ: begin op_class = ClsDjnz; two_byte = 1'b1; alu_op = ALU_DEC; end
      OP_HLT:  op_class = ClsHlt;
      default: illegal = 1'b1;
    endcase
    if (op_uses_reg(op) && (reg_sel > REG_LAST)) begin
      illegal  = 1'b1;
      op_class = ClsNop;
      alu_op   = ALU_ADD;
      two_byte = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 8-bit CPU. Fetches one- or two-byte
// instructions from RAM and steers the register file, ALU and RAM.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_dout,
  input  logic       alu_zero,
  output logic [7:0] mem_addr,
  output logic       mem_re,
  output logic       mem_we,
  output logic       rf_we,
  output logic [2:0] rf_wa,
  output logic [2:0] rf_ra,
  output logic [2:0] rf_rb,
  output logic [1:0] wd_sel,
  output logic [2:0] alu_op,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opr_q, opr_d;

  // In DECODE the instruction byte is still on mem_dout; afterwards it lives in IR
  logic [7:0] dec_ir;
  logic [2:0] ir_reg;
  op_class_e  dec_class;
  logic [2:0] dec_alu_op;
  logic       dec_two_byte;
  logic       dec_illegal;

  assign dec_ir = (state_q == StDecode) ? mem_dout : ir_q;
  assign ir_reg = ir_q[2:0];

  cpu_decoder u_decoder (
    .ir       (dec_ir),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .two_byte (dec_two_byte),
    .illegal  (dec_illegal)
  );

  // State, PC and instruction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

  // Next-state, PC and operand-latch logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d = mem_dout;
        pc_d = pc_q + 8'd1;
        if (dec_illegal) begin
          state_d = StFetch;
        end else if (dec_class == ClsHlt) begin
          state_d = StHalt;
        end else if (dec_two_byte) begin
          state_d = StFetchOp;
        end else if ((dec_class == ClsAlu) || (dec_class == ClsMov)) begin
          state_d = StExec;
        end else begin
          state_d = StFetch;
        end
      end
      StFetchOp: state_d = StLatchOp;
      StLatchOp: begin
        opr_d = mem_dout;
        pc_d  = pc_q + 8'd1;
        case (dec_class)
          ClsJmp: begin
            pc_d    = mem_dout;
            state_d = StFetch;
          end
          ClsLd, ClsSt, ClsDjnz: state_d = StExec;
          default: state_d = StFetch;
        endcase
      end
      StExec: begin
        state_d = (dec_class == ClsLd) ? StMemWait : StFetch;
        // Branch decision uses the ALU result of COUNT-1 computed this cycle
        if ((dec_class == ClsDjnz) && !alu_zero) begin
          pc_d = opr_q;
        end
      end
      StMemWait: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  // Moore output decode; everything is held at zero while reset is high
  always_comb begin
    mem_addr = 8'h00;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = 3'd0;
    rf_ra    = 3'd0;
    rf_rb    = 3'd0;
    wd_sel   = WD_ALU;
    alu_op   = ALU_ADD;
    halted   = 1'b0;
    illegal  = 1'b0;
    pc       = reset ? 8'h00 : pc_q;
    if (!reset) begin
      case (state_q)
        StFetch, StFetchOp: begin
          mem_addr = pc_q;
          mem_re   = 1'b1;
        end
        StDecode: illegal = dec_illegal;
        StLatchOp: begin
          if (dec_class == ClsLdi) begin
            rf_we  = 1'b1;
            rf_wa  = ir_reg;
            wd_sel = WD_MEM;
          end
        end
        StExec: begin
          case (dec_class)
            ClsAlu: begin
              rf_ra  = REG_ACC;
              rf_rb  = ir_reg;
              rf_wa  = REG_ACC;
              alu_op = dec_alu_op;
              wd_sel = WD_ALU;
              rf_we  = 1'b1;
            end
            ClsMov: begin
              rf_ra  = REG_ACC;
              rf_wa  = ir_reg;
              wd_sel = WD_ACC;
              rf_we  = 1'b1;
            end
            ClsSt: begin
              mem_addr = opr_q;
              mem_we   = 1'b1;
              rf_ra    = ir_reg;
            end
            ClsLd: begin
              mem_addr = opr_q;
              mem_re   = 1'b1;
            end
            ClsDjnz: begin
              rf_ra  = REG_COUNT;
              rf_wa  = REG_COUNT;
              alu_op = ALU_DEC;
              wd_sel = WD_ALU;
              rf_we  = 1'b1;
            end
            default: ;
          endcase
        end
        StMemWait: begin
          rf_we  = 1'b1;
          rf_wa  = ir_reg;
          wd_sel = WD_MEM;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a small RAM, register-file and
// ALU model closing the loop around the sequencer.
module tb_cpu_control_unit;

  logic       clk;
  logic       reset;
  logic [7:0] mem_dout;
  logic       alu_zero;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic       mem_we;
  logic       rf_we;
  logic [2:0] rf_wa;
  logic [2:0] rf_ra;
  logic [2:0] rf_rb;
  logic [1:0] wd_sel;
  logic [2:0] alu_op;
  logic [7:0] pc;
  logic       halted;
  logic       illegal;

  int checks;
  int failures;

  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] ram [256];
  logic [7:0] rf [8];
  logic [7:0] alu_a, alu_b, alu_c, wd;

  cpu_control_unit dut (
    .clk      (clk),
    .reset    (reset),
    .mem_dout (mem_dout),
    .alu_zero (alu_zero),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_ra    (rf_ra),
    .rf_rb    (rf_rb),
    .wd_sel   (wd_sel),
    .alu_op   (alu_op),
    .pc       (pc),
    .halted   (halted),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: ALU and write-data mux
  always_comb begin
    alu_a = rf[rf_ra];
    alu_b = rf[rf_rb];
    case (alu_op)
      3'd0:    alu_c = alu_a + alu_b;
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a & alu_b;
      3'd3:    alu_c = alu_a | alu_b;
      3'd4:    alu_c = alu_a ^ alu_b;
      3'd5:    alu_c = alu_a - 8'd1;
      default: alu_c = 8'h00;
    endcase
    case (wd_sel)
      2'd0:    wd = alu_c;
      2'd1:    wd = rf[3];
      2'd2:    wd = mem_dout;
      default: wd = 8'h00;
    endcase
  end
  assign alu_zero = (alu_c == 8'h00);

  // RAM with one-cycle read latency, bench load port and register-file writes
  always_ff @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_we) ram[mem_addr] <= rf[rf_ra];
    if (mem_re) mem_dout <= ram[mem_addr];
    if (rf_we) rf[rf_wa] <= wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      check("excl", 32'(mem_we & (mem_re | rf_we)), 32'd0);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Release reset on a falling edge; returns in cycle 1 (FETCH)
  task automatic start();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  logic [7:0] saved;
  logic       bad;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = 8'h00;
    load_data = 8'h00;
    #1;
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);

    // LDI r0,0x2A ; HLT
    load(8'h00, 8'h08); load(8'h01, 8'h2A); load(8'h02, 8'hF8);
    start();
    check("ldi_c1_re", 32'(mem_re), 32'd1);
    check("ldi_c1_addr", 32'(mem_addr), 32'h00);
    step(3);
    check("ldi_c4_we", 32'(rf_we), 32'd1);
    check("ldi_c4_wa", 32'(rf_wa), 32'd0);
    check("ldi_c4_wdsel", 32'(wd_sel), 32'd2);
    check("ldi_c4_dout", 32'(mem_dout), 32'h2A);
    step(1);
    check("ldi_pc", 32'(pc), 32'h02);
    check("ldi_r0", 32'(rf[0]), 32'h2A);
    step(2);
    check("hlt_halted", 32'(halted), 32'd1);

    // LDI r0,0x2A ; LDI r3,5 ; ADD r0 ; HLT
    reset = 1'b1;
    #1;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc2", 32'(pc), 32'd0);
    check("rst_strobes", 32'({mem_re, mem_we, rf_we, illegal}), 32'd0);
    load(8'h02, 8'h0B); load(8'h03, 8'h05); load(8'h04, 8'h20); load(8'h05, 8'hF8);
    start();
    step(10);
    check("add_ra", 32'(rf_ra), 32'd3);
    check("add_rb", 32'(rf_rb), 32'd0);
    check("add_op", 32'(alu_op), 32'd0);
    check("add_wa", 32'(rf_wa), 32'd3);
    check("add_we", 32'(rf_we), 32'd1);
    check("add_wdsel", 32'(wd_sel), 32'd0);
    step(1);
    check("add_pc", 32'(pc), 32'h05);
    check("add_acc", 32'(rf[3]), 32'h2F);
    step(2);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bad = bad | mem_re | mem_we | rf_we | illegal | !halted;
      step(1);
    end
    check("halt_quiet", 32'(bad), 32'd0);

    // LDI r4,3 ; DJNZ 0x02 ; HLT
    reset = 1'b1;
    load(8'h00, 8'h0C); load(8'h01, 8'h03); load(8'h02, 8'h58); load(8'h03, 8'h02);
    load(8'h04, 8'hF8);
    start();
    step(4);
    for (int p = 0; p < 3; p++) begin
      step(4);
      check("djnz_we", 32'(rf_we), 32'd1);
      check("djnz_ra_wa", 32'({rf_ra, rf_wa}), 32'({3'd4, 3'd4}));
      check("djnz_op", 32'(alu_op), 32'd5);
      check("djnz_zero", 32'(alu_zero), (p == 2) ? 32'd1 : 32'd0);
      step(1);
      check("djnz_pc", 32'(pc), (p == 2) ? 32'h04 : 32'h02);
    end
    check("djnz_count", 32'(rf[4]), 32'd0);

    // LDI r1,0x5C ; ST r1,[0x80] ; LD r2,[0x80] ; HLT
    reset = 1'b1;
    load(8'h80, 8'h00);
    load(8'h00, 8'h09); load(8'h01, 8'h5C); load(8'h02, 8'h19); load(8'h03, 8'h80);
    load(8'h04, 8'h12); load(8'h05, 8'h80); load(8'h06, 8'hF8);
    start();
    step(8);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_addr", 32'(mem_addr), 32'h80);
    check("st_ra", 32'(rf_ra), 32'd1);
    step(1);
    check("st_ram", 32'(ram[8'h80]), 32'h5C);
    step(4);
    check("ld_re", 32'(mem_re), 32'd1);
    check("ld_addr", 32'(mem_addr), 32'h80);
    check("ld_nowe", 32'(rf_we), 32'd0);
    step(1);
    check("ld_we", 32'(rf_we), 32'd1);
    check("ld_wa", 32'(rf_wa), 32'd2);
    check("ld_wdsel", 32'(wd_sel), 32'd2);
    step(1);
    check("ld_pc", 32'(pc), 32'h06);
    check("ld_r2", 32'(rf[2]), 32'h5C);

    // Illegal opcode 0x60 and ADD r5 (0x25)
    reset = 1'b1;
    load(8'h00, 8'h60); load(8'h01, 8'h25); load(8'h02, 8'hF8);
    start();
    step(1);
    check("ill1_pulse", 32'(illegal), 32'd1);
    check("ill1_we", 32'(rf_we), 32'd0);
    step(1);
    check("ill1_done", 32'(illegal), 32'd0);
    check("ill1_pc", 32'(pc), 32'h01);
    step(1);
    check("ill2_pulse", 32'(illegal), 32'd1);
    check("ill2_we", 32'(rf_we), 32'd0);
    step(1);
    check("ill2_done", 32'(illegal), 32'd0);
    check("ill2_pc", 32'(pc), 32'h02);

    // Reset during LD's MEM_WAIT
    reset = 1'b1;
    load(8'h80, 8'h77);
    load(8'h00, 8'h12); load(8'h01, 8'h80);
    saved = rf[2];
    start();
    step(5);
    check("mw_we_before", 32'(rf_we), 32'd1);
    reset = 1'b1;
    #1;
    check("mw_rst_we", 32'(rf_we), 32'd0);
    check("mw_rst_pc", 32'(pc), 32'd0);
    start();
    check("mw_restart", 32'({mem_re, mem_addr, pc}), 32'({1'b1, 8'h00, 8'h00}));
    check("mw_r2_kept", 32'(rf[2]), 32'(saved));

    // JMP 0xFF ; NOP at 0xFF wraps pc
    reset = 1'b1;
    load(8'h00, 8'h50); load(8'h01, 8'hFF); load(8'hFF, 8'h00);
    start();
    step(4);
    check("jmp_pc", 32'(pc), 32'hFF);
    check("jmp_addr", 32'(mem_addr), 32'hFF);
    step(2);
    check("wrap_pc", 32'(pc), 32'h00);

    reset = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
